// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM with bus locking, lock timeout and misaligned-store blocking.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise m0 has fixed priority.
module ram_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [1:0]  m0_mem_ctrl,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [1:0]  m1_mem_ctrl,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_we,
  output logic [1:0]  ram_mem_ctrl,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  localparam int unsigned CW = $clog2(LOCK_MAX) + 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);
  localparam logic [1:0] MC_STORE_HW = 2'b01;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic          prio_sel;
  logic          any_gnt, illegal;
  logic          sel_we;
  logic [1:0]    sel_ctrl;
  logic [31:0]   sel_addr, sel_wdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;
  assign prio_sel = prio_q;
`else
  assign prio_sel = 1'b0;
`endif

  // Grant is gated by reset so nothing reaches the RAM while rst is held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            m0_gnt = !prio_sel;
            m1_gnt = prio_sel;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        OWN0:    m0_gnt = m0_req;
        OWN1:    m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt   = m0_gnt | m1_gnt;
  assign sel_we    = m1_gnt ? m1_we       : m0_we;
  assign sel_ctrl  = m1_gnt ? m1_mem_ctrl : m0_mem_ctrl;
  assign sel_addr  = m1_gnt ? m1_addr     : m0_addr;
  assign sel_wdata = m1_gnt ? m1_wdata    : m0_wdata;
  assign illegal   = sel_we && (sel_ctrl == MC_STORE_HW) && (sel_addr[1:0] == 2'b11);

  assign ram_we       = any_gnt & sel_we & ~illegal;
  assign ram_mem_ctrl = any_gnt ? sel_ctrl  : '0;
  assign ram_address  = any_gnt ? sel_addr  : '0;
  assign ram_data_in  = any_gnt ? sel_wdata : '0;

  assign m0_rvalid_d = m0_gnt & ~sel_we;
  assign m1_rvalid_d = m1_gnt & ~sel_we;
  assign m0_err_d    = m0_gnt & illegal;
  assign m1_err_d    = m1_gnt & illegal;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    prio_d     = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_gnt) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
          prio_d = 1'b1;
`endif
          if (m0_lock) begin
            state_d    = OWN0;
            lock_cnt_d = CW'(1);
          end
        end else if (m1_gnt) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
          prio_d = 1'b0;
`endif
          if (m1_lock) begin
            state_d    = OWN1;
            lock_cnt_d = CW'(1);
          end
        end
      end
      OWN0: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          prio_d     = 1'b1;
`endif
        end else if (!m0_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      OWN1: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          prio_d     = 1'b0;
`endif
        end else if (!m1_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      prio_q      <= prio_d;
`endif
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = ram_data_out;
  assign m1_rdata  = ram_data_out;

endmodule
